// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and limits for the time-of-day counter
// Purpose: FSM state encoding, packed two-digit BCD type, field limits and a
//          helper that converts an integer limit into packed BCD.
// Ports:   none (package).
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } clk_state_t;

    typedef logic [7:0] bcd2_t;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    // Split a 0..99 integer into tens/ones nibbles.
    function automatic bcd2_t to_bcd2(input int value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(value / 10);
        ones = 4'(value % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit packed-BCD counter with wrap at MAX
// Purpose: counts 00..MAX in packed BCD, one step per cycle with en high.
// Ports:   mclk  - clock, rising edge
//          reset - asynchronous, active-low
//          en    - advance by one
//          clr   - synchronous clear to 00, overrides en
//          q     - registered count, [7:4] tens, [3:0] ones
//          wrap  - combinational: en high while q equals MAX
module bcd2_counter
    import clock_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic  mclk,
    input  logic  reset,
    input  logic  en,
    input  logic  clr,
    output bcd2_t q,
    output logic  wrap
);

    localparam bcd2_t MAX_BCD = to_bcd2(MAX);

    logic [3:0] tens;
    logic [3:0] ones;
    logic       non_bcd;
    bcd2_t      q_next;

    assign tens    = q[7:4];
    assign ones    = q[3:0];
    assign non_bcd = (tens > 4'd9) || (ones > 4'd9);
    assign wrap    = en && (q == MAX_BCD);

    always_comb begin
        q_next = q;
        if (clr) begin
            q_next = 8'h00;
        end else if (en) begin
            // A corrupted digit recovers to 00 rather than counting onward.
            if (non_bcd || (q == MAX_BCD)) begin
                q_next = 8'h00;
            end else if (ones == 4'd9) begin
                q_next = {4'(tens + 4'd1), 4'd0};
            end else begin
                q_next = {tens, 4'(ones + 4'd1)};
            end
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            q <= 8'h00;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/hms_time_counter.sv
// rtl/hms_time_counter.sv - BCD hours:minutes:seconds counter with set mode
// Purpose: counts time of day from a 1 Hz tick; mode/inc buttons set hours
//          and minutes.
// Ports:   mclk     - clock, rising edge
//          reset    - asynchronous, active-low
//          tick     - 1 Hz one-cycle enable
//          mode     - one-cycle pulse, advances RUN -> SET_HOUR -> SET_MIN
//          inc      - one-cycle pulse, increments the field being set
//          sec_bcd  - seconds, packed BCD
//          min_bcd  - minutes, packed BCD
//          hour_bcd - hours, packed BCD
//          state    - 0 RUN, 1 SET_HOUR, 2 SET_MIN
//          day_rco  - one-cycle pulse coincident with the 00:00:00 rollover
module hms_time_counter
    import clock_pkg::*;
#(
    parameter int HOUR_MAX = 23
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       tick,
    input  logic       mode,
    input  logic       inc,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic [1:0] state,
    output logic       day_rco
);

    clk_state_t state_q;
    clk_state_t state_d;

    logic run;
    logic sec_en;
    logic min_en;
    logic hour_en;
    logic sec_clr;
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;

    assign run = (state_q == RUN);

    // In RUN the carry chain drives each field; in set states only inc drives
    // the selected field, and a coincident mode pulse drops the inc.
    assign sec_en  = run && tick;
    assign min_en  = run ? sec_wrap : ((state_q == SET_MIN) && inc && !mode);
    assign hour_en = run ? min_wrap : ((state_q == SET_HOUR) && inc && !mode);
    assign sec_clr = (state_q == SET_MIN) && mode;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mode) state_d = SET_HOUR;
            SET_HOUR: if (mode) state_d = SET_MIN;
            SET_MIN:  if (mode) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            day_rco <= 1'b0;
        end else begin
            state_q <= state_d;
            // Hour wraps while setting must not look like a new day.
            day_rco <= run && hour_wrap;
        end
    end

    assign state = state_q;

    bcd2_counter #(.MAX(SEC_MAX)) u_sec (
        .mclk  (mclk),
        .reset (reset),
        .en    (sec_en),
        .clr   (sec_clr),
        .q     (sec_bcd),
        .wrap  (sec_wrap)
    );

    bcd2_counter #(.MAX(MIN_MAX)) u_min (
        .mclk  (mclk),
        .reset (reset),
        .en    (min_en),
        .clr   (1'b0),
        .q     (min_bcd),
        .wrap  (min_wrap)
    );

    bcd2_counter #(.MAX(HOUR_MAX)) u_hour (
        .mclk  (mclk),
        .reset (reset),
        .en    (hour_en),
        .clr   (1'b0),
        .q     (hour_bcd),
        .wrap  (hour_wrap)
    );

endmodule

// File: tb/tb_hms_time_counter.sv
// tb/tb_hms_time_counter.sv - scoreboard bench for hms_time_counter
module tb_hms_time_counter;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [1:0] st;
        logic       rco;
    } exp_t;

    logic mclk = 1'b0;
    logic reset;
    logic tick0, mode0, inc0;
    logic tick1, mode1, inc1;
    logic [7:0] sec0, min0, hour0, sec1, min1, hour1;
    logic [1:0] state0, state1;
    logic       rco0, rco1;

    always #10 mclk = ~mclk;

    hms_time_counter #(.HOUR_MAX(23)) dut0 (
        .mclk(mclk), .reset(reset), .tick(tick0), .mode(mode0), .inc(inc0),
        .sec_bcd(sec0), .min_bcd(min0), .hour_bcd(hour0), .state(state0),
        .day_rco(rco0)
    );

    hms_time_counter #(.HOUR_MAX(11)) dut1 (
        .mclk(mclk), .reset(reset), .tick(tick1), .mode(mode1), .inc(inc1),
        .sec_bcd(sec1), .min_bcd(min1), .hour_bcd(hour1), .state(state1),
        .day_rco(rco1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int rco_seen = 0;

    int   ms[2];
    int   mm[2];
    int   mh[2];
    int   mst[2];
    logic mrco[2];
    int   hmax[2] = '{23, 11};

    exp_t q0[$];
    exp_t q1[$];

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic exp_t pack(input int d);
        return {bcd(mh[d]), bcd(mm[d]), bcd(ms[d]), 2'(mst[d]), mrco[d]};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ms[d] = 0; mm[d] = 0; mh[d] = 0; mst[d] = 0; mrco[d] = 1'b0;
        end
    endtask

    // Decimal reference model of one clock edge.
    task automatic model_step(input int d, input logic t, input logic mo, input logic in);
        mrco[d] = 1'b0;
        case (mst[d])
            0: begin
                if (t) begin
                    ms[d]++;
                    if (ms[d] == 60) begin
                        ms[d] = 0;
                        mm[d]++;
                        if (mm[d] == 60) begin
                            mm[d] = 0;
                            mh[d]++;
                            if (mh[d] > hmax[d]) begin
                                mh[d] = 0;
                                mrco[d] = 1'b1;
                            end
                        end
                    end
                end
                if (mo) mst[d] = 1;
            end
            1: begin
                if (mo) mst[d] = 2;
                else if (in) mh[d] = (mh[d] == hmax[d]) ? 0 : mh[d] + 1;
            end
            default: begin
                if (mo) begin
                    mst[d] = 0;
                    ms[d] = 0;
                end else if (in) begin
                    mm[d] = (mm[d] + 1) % 60;
                end
            end
        endcase
    endtask

    // One clock cycle of stimulus on DUT d; the other DUT idles.
    task automatic cycle(input int d, input logic t, input logic mo, input logic in);
        exp_t e;
        exp_t a;
        @(negedge mclk);
        tick0 = (d == 0) && t; mode0 = (d == 0) && mo; inc0 = (d == 0) && in;
        tick1 = (d == 1) && t; mode1 = (d == 1) && mo; inc1 = (d == 1) && in;
        model_step(0, tick0, mode0, inc0);
        model_step(1, tick1, mode1, inc1);
        q0.push_back(pack(0));
        q1.push_back(pack(1));
        @(posedge mclk);
        #1;
        e = q0.pop_front();
        a = {hour0, min0, sec0, state0, rco0};
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL cycle_dut0 at %0t: got h%h m%h s%h st%0d rco%b, want h%h m%h s%h st%0d rco%b",
                     $time, a.h, a.m, a.s, a.st, a.rco, e.h, e.m, e.s, e.st, e.rco);
        end
        e = q1.pop_front();
        a = {hour1, min1, sec1, state1, rco1};
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL cycle_dut1 at %0t: got h%h m%h s%h st%0d rco%b, want h%h m%h s%h st%0d rco%b",
                     $time, a.h, a.m, a.s, a.st, a.rco, e.h, e.m, e.s, e.st, e.rco);
        end
        if (rco0 === 1'b1) rco_seen++;
        tick0 = 0; mode0 = 0; inc0 = 0;
        tick1 = 0; mode1 = 0; inc1 = 0;
    endtask

    task automatic apply_reset();
        @(negedge mclk);
        #3 reset = 1'b0;
        model_reset();
        @(negedge mclk);
        reset = 1'b1;
    endtask

    // Load hh:mm:00 through set mode and return to RUN.
    task automatic preload(input int d, input int h, input int m);
        cycle(d, 0, 1, 0);
        for (int i = 0; i < h; i++) cycle(d, 0, 0, 1);
        cycle(d, 0, 1, 0);
        for (int i = 0; i < m; i++) cycle(d, 0, 0, 1);
        cycle(d, 0, 1, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick0 = 0; mode0 = 0; inc0 = 0;
        tick1 = 0; mode1 = 0; inc1 = 0;
        model_reset();
        repeat (2) @(posedge mclk);
        #1;
        n_checks++;
        if ({hour0, min0, sec0, state0, rco0} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_dut0: got %h, want 0", {hour0, min0, sec0, state0, rco0});
        end
        n_checks++;
        if ({hour1, min1, sec1, state1, rco1} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: got %h, want 0", {hour1, min1, sec1, state1, rco1});
        end
        @(negedge mclk);
        reset = 1'b1;
    endtask

    task automatic test_seconds();
        apply_reset();
        rco_seen = 0;
        for (int i = 0; i < 59; i++) cycle(0, 1, 0, 0);
        n_checks++;
        if (sec0 !== 8'h59 || min0 !== 8'h00 || rco_seen != 0) begin
            n_fail++;
            $display("FAIL sec59: got s%h m%h rco_count %0d, want s59 m00 rco_count 0", sec0, min0, rco_seen);
        end
        cycle(0, 1, 0, 0);
        n_checks++;
        if (sec0 !== 8'h00 || min0 !== 8'h01) begin
            n_fail++;
            $display("FAIL sec_carry: got s%h m%h, want s00 m01", sec0, min0);
        end
    endtask

    task automatic test_day_wrap();
        apply_reset();
        preload(0, 23, 59);
        for (int i = 0; i < 58; i++) cycle(0, 1, 0, 0);
        rco_seen = 0;
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        n_checks++;
        if ({hour0, min0, sec0} !== 24'h000000 || rco0 !== 1'b1) begin
            n_fail++;
            $display("FAIL day_wrap: got %h%h%h rco%b, want 000000 rco1", hour0, min0, sec0, rco0);
        end
        cycle(0, 0, 0, 0);
        n_checks++;
        if (rco_seen != 1) begin
            n_fail++;
            $display("FAIL rco_width: got %0d high cycles, want 1", rco_seen);
        end
    endtask

    task automatic test_set_sequence();
        apply_reset();
        cycle(0, 0, 1, 0);
        n_checks++;
        if (state0 !== 2'd1) begin
            n_fail++;
            $display("FAIL to_set_hour: got %0d, want 1", state0);
        end
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        n_checks++;
        if (state0 !== 2'd2) begin
            n_fail++;
            $display("FAIL to_set_min: got %0d, want 2", state0);
        end
        for (int i = 0; i < 61; i++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        n_checks++;
        if (state0 !== 2'd0 || hour0 !== 8'h05 || min0 !== 8'h01 || sec0 !== 8'h00) begin
            n_fail++;
            $display("FAIL set_result: got st%0d %h:%h:%h, want st0 05:01:00", state0, hour0, min0, sec0);
        end
    endtask

    task automatic test_frozen_and_collisions();
        apply_reset();
        preload(0, 7, 42);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 0);
        n_checks++;
        if (state0 !== 2'd1 || sec0 !== 8'h04) begin
            n_fail++;
            $display("FAIL tick_mode_run: got st%0d s%h, want st1 s04", state0, sec0);
        end
        for (int i = 0; i < 30; i++) cycle(0, 1, 0, 0);
        n_checks++;
        if ({hour0, min0, sec0} !== 24'h074204) begin
            n_fail++;
            $display("FAIL frozen: got %h:%h:%h, want 07:42:04", hour0, min0, sec0);
        end
        cycle(0, 0, 1, 1);
        n_checks++;
        if (state0 !== 2'd2 || hour0 !== 8'h07) begin
            n_fail++;
            $display("FAIL mode_beats_inc: got st%0d h%h, want st2 h07", state0, hour0);
        end
        cycle(0, 1, 0, 1);
        n_checks++;
        if (min0 !== 8'h43 || sec0 !== 8'h04) begin
            n_fail++;
            $display("FAIL tick_inc_set: got m%h s%h, want m43 s04", min0, sec0);
        end
        cycle(0, 0, 1, 0);
    endtask

    task automatic test_hour_max_11();
        apply_reset();
        preload(1, 11, 59);
        for (int i = 0; i < 59; i++) cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        n_checks++;
        if ({hour1, min1, sec1} !== 24'h000000 || rco1 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap11: got %h:%h:%h rco%b, want 00:00:00 rco1", hour1, min1, sec1, rco1);
        end
        cycle(1, 0, 1, 0);
        for (int i = 0; i < 11; i++) cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        n_checks++;
        if (hour1 !== 8'h00 || rco1 !== 1'b0) begin
            n_fail++;
            $display("FAIL set_wrap11: got h%h rco%b, want h00 rco0", hour1, rco1);
        end
        cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 0);
    endtask

    task automatic test_async_reset();
        apply_reset();
        preload(0, 12, 34);
        for (int i = 0; i < 56; i++) cycle(0, 1, 0, 0);
        @(negedge mclk);
        #3 reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({hour0, min0, sec0, state0, rco0} !== 27'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h:%h:%h st%0d, want 00:00:00 st0", hour0, min0, sec0, state0);
        end
        @(negedge mclk);
        reset = 1'b1;
        cycle(0, 1, 0, 0);
        n_checks++;
        if (sec0 !== 8'h01) begin
            n_fail++;
            $display("FAIL first_tick_after_reset: got s%h, want s01", sec0);
        end
    endtask

    initial begin
        test_reset();
        test_seconds();
        test_day_wrap();
        test_set_sequence();
        test_frozen_and_collisions();
        test_hour_max_11();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
